branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  Consumer end of the IF-stage branch predictor: carries each fetch's prediction (taken/target/BTB hit) across IF->ID,
//  compares it with the outcome resolved in ID, and issues the redirect/flush on mispredict.
//  Emits the registered training strobe (upd_*) that the predictor's ID-side update port consumes, plus saturating perf counters.
// PARAMETERS
//  CNT_W    32  width of each perf counter
//  RST_PC   0   value of redirect_pc and upd_pc/upd_target out of reset
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  if_valid       in   1   IF holds a valid fetched instruction
//  if_pc          in   32  PC of the IF instruction
//  if_pred_taken  in   1   predictor predict_do_branch (taken AND BTB hit)
//  if_pred_pc     in   32  predictor next-PC (BTB target or if_pc+4)
//  if_btb_hit     in   1   BTB tag hit for if_pc
//  id_stall       in   1   ID stalled: hold metadata, no resolve
//  id_flush_ext   in   1   external flush (trap/exception), highest priority
//  id_valid       in   1   ID holds a valid instruction
//  id_pc          in   32  PC of ID instruction
//  id_is_branch   in   1   conditional branch in ID
//  id_is_jump     in   1   JAL/JALR in ID (always taken)
//  id_taken       in   1   resolved condition (ignored unless id_is_branch)
//  id_target      in   32  resolved branch/jump target
//  redirect_ready in   1   fetch unit accepts redirect this cycle
//  redirect_valid out  1   redirect request (combinational in RUN, registered in HOLD)
//  redirect_pc    out  32  correct next PC
//  flush_if       out  1   kill IF instruction (= redirect_valid | id_flush_ext)
//  upd_branch     out  1   1-cycle training strobe (maps to predictor ID_branch)
//  upd_taken      out  1   actual taken (maps to ID_taken)
//  upd_pc         out  32  trained PC (ID_PC)
//  upd_target     out  32  trained target (ID_Jump_PC)
//  meta_err       out  1   sticky: meta_q.pc != id_pc on a resolve
//  cnt_ctrl       out  CNT_W resolved branches+jumps
//  cnt_mispred    out  CNT_W mispredicts (incl. non-control predicted taken)
//  cnt_btb_hit    out  CNT_W resolves whose prediction had BTB hit
// BEHAVIOUR
//  Reset: state=RUN, meta_q.valid=0, all upd_* / redirect_valid / meta_err / counters =0, redirect_pc=RST_PC.
//  meta_q {valid,pc,pred_taken,pred_pc,btb_hit}: loads IF fields when state==RUN & !id_stall & !flush_if;
//   cleared (valid=0) on flush_if; holds on id_stall.
//  resolve = state==RUN & id_valid & meta_q.valid & !id_stall & !id_flush_ext.
//  actual_taken = id_is_jump | (id_is_branch & id_taken); actual_pc = actual_taken ? id_target : id_pc+4 (mod 2^32).
//  mispredict = resolve & (actual_pc != meta_q.pred_pc); covers a non-control op predicted taken (BTB alias).
//  RUN: mispredict -> redirect_valid=1, redirect_pc=actual_pc same cycle (0 latency);
//   redirect_ready=1 -> stay RUN; else capture actual_pc into redirect register, go HOLD.
//  HOLD: redirect_valid=1 from register; no meta loads, no resolve; redirect_ready -> RUN.
//  id_flush_ext in either state: redirect_valid=0, meta_q cleared, state->RUN next edge (pending redirect dropped).
//  Training: edge after resolve with (id_is_branch|id_is_jump): upd_branch=1 for exactly 1 cycle,
//   upd_taken=actual_taken, upd_pc=id_pc, upd_target=id_target; upd_* fields hold last value otherwise.
//   Non-control resolves never train.
//  Counters: +1 on the resolve edge; saturate at all-ones, no wrap. meta_err clears only on rst.
//  rst mid-HOLD: redirect dropped, all state to reset values asynchronously.
// STRUCTURE
//  Shared pkg: state encoding (RUN=1'b0, HOLD=1'b1), meta_t field layout/widths, PC_INC=32'd4.
//  One sub-module natural: sat_counter (CNT_W, inc, rst) instantiated three times.
// TESTING
//  1. Predict NT, branch at 0x100 not taken -> no redirect, upd_branch=1 upd_taken=0 next cycle, cnt_mispred=0.
//  2. Pred_pc=0x104, branch 0x100 taken to 0x200 -> redirect_valid=1 redirect_pc=0x200 same cycle, flush_if=1, cnt_mispred=1.
//  3. Same as 2 with redirect_ready=0 for 3 cycles -> HOLD, redirect_pc stays 0x200, no meta load; RUN after ready.
//  4. ADD at 0x40 with if_pred_taken=1 pred_pc=0x80 -> redirect 0x44, upd_branch stays 0, cnt_ctrl unchanged.
//  5. id_flush_ext during HOLD -> redirect_valid=0 that cycle, RUN next; id_stall 2 cycles -> meta_q unchanged, no counts.
//  6. Force cnt_ctrl=all-ones, resolve a jump -> stays all-ones; id_pc!=meta_q.pc -> meta_err=1 until rst.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Purpose: shared types for the branch resolver: FSM state encoding, the
//          IF->ID prediction metadata layout and the training strobe payload.
// Ports:   none (package).
package branch_resolver_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  // RUN: redirects issue combinationally; HOLD: a redirect waits for fetch
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Prediction made in IF, carried alongside the instruction into ID
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_pc;
    logic            btb_hit;
  } meta_t;

  // Training strobe consumed by the predictor's ID-side update port
  typedef struct packed {
    logic            branch;
    logic            taken;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
  } upd_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Purpose: bundles the IF prediction, ID outcome, redirect handshake,
//          training strobe and perf counter signals of the branch resolver.
// Modports:
//   master - pipeline/fetch side: drives IF/ID fields and redirect_ready,
//            observes redirect, flush, training and counters.
//   slave  - branch_resolver side.
interface branch_resolver_if #(
  parameter int unsigned CNT_W = 32
);
  import branch_resolver_pkg::*;

  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic             if_pred_taken;
  logic [PC_W-1:0]  if_pred_pc;
  logic             if_btb_hit;
  logic             id_stall;
  logic             id_flush_ext;
  logic             id_valid;
  logic [PC_W-1:0]  id_pc;
  logic             id_is_branch;
  logic             id_is_jump;
  logic             id_taken;
  logic [PC_W-1:0]  id_target;
  logic             redirect_ready;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_if;
  logic             upd_branch;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_pc;
  logic [PC_W-1:0]  upd_target;
  logic             meta_err;
  logic [CNT_W-1:0] cnt_ctrl;
  logic [CNT_W-1:0] cnt_mispred;
  logic [CNT_W-1:0] cnt_btb_hit;

  modport master (
    output if_valid, if_pc, if_pred_taken, if_pred_pc, if_btb_hit,
    output id_stall, id_flush_ext, id_valid, id_pc, id_is_branch, id_is_jump,
    output id_taken, id_target, redirect_ready,
    input  redirect_valid, redirect_pc, flush_if,
    input  upd_branch, upd_taken, upd_pc, upd_target,
    input  meta_err, cnt_ctrl, cnt_mispred, cnt_btb_hit
  );

  modport slave (
    input  if_valid, if_pc, if_pred_taken, if_pred_pc, if_btb_hit,
    input  id_stall, id_flush_ext, id_valid, id_pc, id_is_branch, id_is_jump,
    input  id_taken, id_target, redirect_ready,
    output redirect_valid, redirect_pc, flush_if,
    output upd_branch, upd_taken, upd_pc, upd_target,
    output meta_err, cnt_ctrl, cnt_mispred, cnt_btb_hit
  );

endinterface

// File: rtl/branch_resolver_sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, rst - clock, asynchronous active-high reset (clears to 0)
//   inc_i    - add one this cycle (ignored once saturated)
//   count_o  - current count
module branch_resolver_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: increment unless already all-ones
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Purpose: consumer end of the IF-stage branch predictor. Carries each
//          fetch's prediction across IF->ID, checks it against the outcome
//          resolved in ID, issues redirect/flush on mispredict, emits a
//          one-cycle training strobe and keeps saturating perf counters.
// Ports:
//   clk, rst - clock (rising edge), asynchronous active-high reset
//   br       - slave side of branch_resolver_if: IF prediction, ID outcome,
//              redirect handshake (redirect_valid/redirect_pc/redirect_ready),
//              flush_if, upd_* training strobe, meta_err, cnt_* counters
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned     CNT_W  = 32,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  branch_resolver_if.slave   br
);

  state_e          state_q, state_d;
  meta_t           meta_q, meta_d;
  upd_t            upd_q, upd_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;
  logic            meta_err_q, meta_err_d;

  logic            is_ctrl_c;
  logic            actual_taken_c;
  logic [PC_W-1:0] actual_pc_c;
  logic            resolve_c;
  logic            mispredict_c;
  logic            redirect_valid_c;
  logic [PC_W-1:0] redirect_pc_c;
  logic            flush_if_c;

  logic [CNT_W-1:0] cnt_ctrl_c, cnt_mispred_c, cnt_btb_hit_c;

  // Outcome of the ID instruction and comparison with the carried prediction.
  // A non-control op whose fetch was predicted taken (BTB alias) also counts
  // as a mispredict because its real next PC is pc+4.
  always_comb begin
    is_ctrl_c      = br.id_is_branch | br.id_is_jump;
    actual_taken_c = br.id_is_jump | (br.id_is_branch & br.id_taken);
    actual_pc_c    = actual_taken_c ? br.id_target : (br.id_pc + PC_INC);
    resolve_c      = (state_q == RUN) & br.id_valid & meta_q.valid &
                     ~br.id_stall & ~br.id_flush_ext;
    mispredict_c   = resolve_c & (actual_pc_c != meta_q.pred_pc);
  end

  // Redirect FSM: zero-latency redirect in RUN, parked in HOLD until fetch
  // accepts; an external flush overrides and drops any pending redirect.
  always_comb begin
    state_d          = state_q;
    redir_pc_d       = redir_pc_q;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = redir_pc_q;
    case (state_q)
      RUN: begin
        if (mispredict_c) begin
          redirect_valid_c = 1'b1;
          redirect_pc_c    = actual_pc_c;
          redir_pc_d       = actual_pc_c;
          if (!br.redirect_ready) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        redirect_valid_c = 1'b1;
        if (br.redirect_ready) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (br.id_flush_ext) begin
      redirect_valid_c = 1'b0;
      state_d          = RUN;
    end
  end

  assign flush_if_c = redirect_valid_c | br.id_flush_ext;

  // Prediction metadata: follows IF while the pipe advances, frozen on stall,
  // invalidated whenever the IF instruction is killed.
  always_comb begin
    meta_d = meta_q;
    if (flush_if_c) begin
      meta_d.valid = 1'b0;
    end else if ((state_q == RUN) && !br.id_stall) begin
      meta_d.valid      = br.if_valid;
      meta_d.pc         = br.if_pc;
      meta_d.pred_taken = br.if_pred_taken;
      meta_d.pred_pc    = br.if_pred_pc;
      meta_d.btb_hit    = br.if_btb_hit;
    end
  end

  // Training strobe pulses for one cycle after a control-op resolve;
  // payload fields keep their last value between pulses.
  always_comb begin
    upd_d        = upd_q;
    upd_d.branch = 1'b0;
    if (resolve_c && is_ctrl_c) begin
      upd_d.branch = 1'b1;
      upd_d.taken  = actual_taken_c;
      upd_d.pc     = br.id_pc;
      upd_d.target = br.id_target;
    end
    meta_err_d = meta_err_q | (resolve_c & (meta_q.pc != br.id_pc));
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      meta_q       <= '0;
      upd_q.branch <= 1'b0;
      upd_q.taken  <= 1'b0;
      upd_q.pc     <= RST_PC;
      upd_q.target <= RST_PC;
      redir_pc_q   <= RST_PC;
      meta_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      upd_q      <= upd_d;
      redir_pc_q <= redir_pc_d;
      meta_err_q <= meta_err_d;
    end
  end

  // Perf counters, all stepping on the resolve edge
  branch_resolver_sat_counter #(.CNT_W(CNT_W)) u_cnt_ctrl (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resolve_c & is_ctrl_c),
    .count_o (cnt_ctrl_c)
  );

  branch_resolver_sat_counter #(.CNT_W(CNT_W)) u_cnt_mispred (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (mispredict_c),
    .count_o (cnt_mispred_c)
  );

  branch_resolver_sat_counter #(.CNT_W(CNT_W)) u_cnt_btb_hit (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resolve_c & meta_q.btb_hit),
    .count_o (cnt_btb_hit_c)
  );

  // pred_taken is carried for debug visibility; the redirect decision uses pred_pc
  logic unused_c;
  assign unused_c = meta_q.pred_taken;

  assign br.redirect_valid = redirect_valid_c;
  assign br.redirect_pc    = redirect_pc_c;
  assign br.flush_if       = flush_if_c;
  assign br.upd_branch     = upd_q.branch;
  assign br.upd_taken      = upd_q.taken;
  assign br.upd_pc         = upd_q.pc;
  assign br.upd_target     = upd_q.target;
  assign br.meta_err       = meta_err_q;
  assign br.cnt_ctrl       = cnt_ctrl_c;
  assign br.cnt_mispred    = cnt_mispred_c;
  assign br.cnt_btb_hit    = cnt_btb_hit_c;

endmodule

// File: tb/tb_branch_resolver.sv
// Purpose: self-checking bench for branch_resolver. A table of IF->ID
// prediction/outcome pairs plus hand-written HOLD, flush, stall, saturation,
// meta_err and mid-HOLD reset sequences. Training strobes are checked
// through a scoreboard queue filled when a resolve is driven.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;
  localparam logic [31:0] RST_PC  = 32'hA000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if #(.CNT_W(CNT_W)) bus ();

  branch_resolver #(.CNT_W(CNT_W), .RST_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int m_ctrl  = 0;
  int m_mis   = 0;
  int m_btb   = 0;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } upd_exp_t;
  upd_exp_t sb_q[$];

  typedef struct {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        btb_hit;
    logic        is_branch;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
    logic        exp_redir;
    logic [31:0] exp_rpc;
    logic        exp_train;
    logic        exp_taken;
  } vec_t;
  vec_t vecs[8];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic chk_cnt(input string tag);
    chk32({tag, "_cnt_ctrl"},    32'(bus.cnt_ctrl),    32'(m_ctrl));
    chk32({tag, "_cnt_mispred"}, 32'(bus.cnt_mispred), 32'(m_mis));
    chk32({tag, "_cnt_btb_hit"}, 32'(bus.cnt_btb_hit), 32'(m_btb));
  endtask

  task automatic idle();
    bus.if_valid       = 1'b0;
    bus.if_pc          = '0;
    bus.if_pred_taken  = 1'b0;
    bus.if_pred_pc     = '0;
    bus.if_btb_hit     = 1'b0;
    bus.id_stall       = 1'b0;
    bus.id_flush_ext   = 1'b0;
    bus.id_valid       = 1'b0;
    bus.id_pc          = '0;
    bus.id_is_branch   = 1'b0;
    bus.id_is_jump     = 1'b0;
    bus.id_taken       = 1'b0;
    bus.id_target      = '0;
    bus.redirect_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ppc, input logic hit);
    idle();
    bus.if_valid      = 1'b1;
    bus.if_pc         = pc;
    bus.if_pred_taken = pt;
    bus.if_pred_pc    = ppc;
    bus.if_btb_hit    = hit;
  endtask

  task automatic decode(input logic [31:0] pc, input logic br_i, input logic j_i,
                        input logic tk, input logic [31:0] tgt);
    idle();
    bus.id_valid     = 1'b1;
    bus.id_pc        = pc;
    bus.id_is_branch = br_i;
    bus.id_is_jump   = j_i;
    bus.id_taken     = tk;
    bus.id_target    = tgt;
  endtask

  // One fetch cycle then one resolve cycle for a table entry
  task automatic run_pair(input vec_t v, input string tag);
    upd_exp_t e;
    fetch(v.pc, v.pred_taken, v.pred_pc, v.btb_hit);
    step();
    decode(v.pc, v.is_branch, v.is_jump, v.taken, v.target);
    #1;
    chk1({tag, "_redirect_valid"}, bus.redirect_valid, v.exp_redir);
    chk1({tag, "_flush_if"}, bus.flush_if, v.exp_redir);
    if (v.exp_redir) chk32({tag, "_redirect_pc"}, bus.redirect_pc, v.exp_rpc);
    if (v.exp_train) begin
      e.taken = v.exp_taken; e.pc = v.pc; e.target = v.target;
      sb_q.push_back(e);
    end
    if (v.is_branch || v.is_jump) m_ctrl = sat(m_ctrl);
    if (v.exp_redir) m_mis = sat(m_mis);
    if (v.btb_hit) m_btb = sat(m_btb);
    step();
    idle();
    chk_cnt(tag);
    chk1({tag, "_meta_err"}, bus.meta_err, 1'b0);
  endtask

  // Mispredict at 0x100 (taken to 0x200, predicted 0x104) with fetch not ready
  task automatic mispredict_to_hold(input string tag);
    upd_exp_t e;
    fetch(32'h100, 1'b0, 32'h104, 1'b0);
    step();
    decode(32'h100, 1'b1, 1'b0, 1'b1, 32'h200);
    bus.redirect_ready = 1'b0;
    #1;
    chk1({tag, "_redirect_valid"}, bus.redirect_valid, 1'b1);
    chk32({tag, "_redirect_pc"}, bus.redirect_pc, 32'h200);
    e.taken = 1'b1; e.pc = 32'h100; e.target = 32'h200;
    sb_q.push_back(e);
    m_ctrl = sat(m_ctrl);
    m_mis  = sat(m_mis);
    step();
  endtask

  // Scoreboard: every training strobe must match the oldest expected entry
  always @(negedge clk) begin : sb_monitor
    upd_exp_t e;
    if (rst === 1'b0 && bus.upd_branch === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk1("upd_unexpected", bus.upd_branch, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk1("upd_taken", bus.upd_taken, e.taken);
        chk32("upd_pc", bus.upd_pc, e.pc);
        chk32("upd_target", bus.upd_target, e.target);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t v;
    //          pc            pt    pred_pc       hit   br    j     tk    target        redir rpc           trn   tkn
    vecs[0] = '{32'h100,      1'b0, 32'h104,      1'b0, 1'b1, 1'b0, 1'b0, 32'h200,      1'b0, 32'h0,        1'b1, 1'b0};
    vecs[1] = '{32'h100,      1'b0, 32'h104,      1'b0, 1'b1, 1'b0, 1'b1, 32'h200,      1'b1, 32'h200,      1'b1, 1'b1};
    vecs[2] = '{32'h40,       1'b1, 32'h80,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h44,       1'b0, 1'b0};
    vecs[3] = '{32'h300,      1'b1, 32'h500,      1'b1, 1'b0, 1'b1, 1'b0, 32'h500,      1'b0, 32'h0,        1'b1, 1'b1};
    vecs[4] = '{32'h400,      1'b1, 32'h480,      1'b1, 1'b1, 1'b0, 1'b0, 32'h480,      1'b1, 32'h404,      1'b1, 1'b0};
    vecs[5] = '{32'h600,      1'b0, 32'h604,      1'b0, 1'b0, 1'b1, 1'b0, 32'h700,      1'b1, 32'h700,      1'b1, 1'b1};
    vecs[6] = '{32'h50,       1'b0, 32'h54,       1'b0, 1'b0, 1'b0, 1'b1, 32'h90,       1'b0, 32'h0,        1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h10,       1'b0, 32'h0,        1'b1, 1'b0};

    // Reset state
    idle();
    rst = 1'b1;
    #12;
    chk1("rst_redirect_valid", bus.redirect_valid, 1'b0);
    chk32("rst_redirect_pc", bus.redirect_pc, RST_PC);
    chk1("rst_upd_branch", bus.upd_branch, 1'b0);
    chk32("rst_upd_pc", bus.upd_pc, RST_PC);
    chk32("rst_upd_target", bus.upd_target, RST_PC);
    chk1("rst_meta_err", bus.meta_err, 1'b0);
    chk_cnt("rst");
    @(negedge clk);
    rst = 1'b0;
    step();

    // Table of single prediction/outcome pairs
    for (int i = 0; i < 8; i++) begin
      run_pair(vecs[i], $sformatf("vec%0d", i));
    end

    // Redirect parked in HOLD for three cycles; IF is not captured meanwhile
    mispredict_to_hold("hold_entry");
    for (int i = 0; i < 3; i++) begin
      fetch(32'h900, 1'b0, 32'h904, 1'b0);
      bus.redirect_ready = 1'b0;
      #1;
      chk1("hold_redirect_valid", bus.redirect_valid, 1'b1);
      chk32("hold_redirect_pc", bus.redirect_pc, 32'h200);
      chk1("hold_flush_if", bus.flush_if, 1'b1);
      step();
    end
    idle();
    #1;
    chk1("hold_accept_valid", bus.redirect_valid, 1'b1);
    step();
    decode(32'h900, 1'b1, 1'b0, 1'b1, 32'h10);
    #1;
    chk1("post_hold_no_resolve", bus.redirect_valid, 1'b0);
    step();
    idle();
    chk_cnt("post_hold");

    // External flush while in HOLD drops the redirect
    mispredict_to_hold("flush_entry");
    idle();
    bus.redirect_ready = 1'b0;
    bus.id_flush_ext   = 1'b1;
    #1;
    chk1("flush_redirect_valid", bus.redirect_valid, 1'b0);
    chk1("flush_flush_if", bus.flush_if, 1'b1);
    step();
    idle();
    bus.redirect_ready = 1'b0;
    #1;
    chk1("flush_back_to_run", bus.redirect_valid, 1'b0);
    step();

    // ID stall: metadata frozen, nothing resolved or counted
    fetch(32'h100, 1'b0, 32'h104, 1'b1);
    step();
    for (int i = 0; i < 2; i++) begin
      decode(32'h100, 1'b1, 1'b0, 1'b1, 32'h200);
      bus.id_stall      = 1'b1;
      bus.if_valid      = 1'b1;
      bus.if_pc         = 32'h1F0;
      bus.if_pred_pc    = 32'h200;
      bus.if_pred_taken = 1'b1;
      #1;
      chk1("stall_redirect_valid", bus.redirect_valid, 1'b0);
      step();
    end
    idle();
    chk_cnt("stall");
    decode(32'h100, 1'b1, 1'b0, 1'b1, 32'h200);
    #1;
    chk1("stall_release_redirect", bus.redirect_valid, 1'b1);
    chk32("stall_release_pc", bus.redirect_pc, 32'h200);
    sb_q.push_back('{1'b1, 32'h100, 32'h200});
    m_ctrl = sat(m_ctrl);
    m_mis  = sat(m_mis);
    m_btb  = sat(m_btb);
    step();
    idle();
    chk_cnt("stall_release");
    chk1("stall_meta_err", bus.meta_err, 1'b0);

    // Drive cnt_ctrl into saturation with correctly predicted jumps
    for (int i = 0; i < 8; i++) begin
      v = '{32'h2000 + 32'(i * 8), 1'b1, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3000,
            1'b0, 32'h0, 1'b1, 1'b1};
      run_pair(v, $sformatf("sat%0d", i));
    end
    chk32("cnt_ctrl_saturated", 32'(bus.cnt_ctrl), 32'hF);

    // Metadata PC disagreeing with ID PC sets the sticky error
    fetch(32'h100, 1'b0, 32'h108, 1'b0);
    step();
    decode(32'h104, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk1("meta_err_no_redirect", bus.redirect_valid, 1'b0);
    step();
    idle();
    chk1("meta_err_set", bus.meta_err, 1'b1);
    chk_cnt("meta_err");
    step();
    step();
    chk1("meta_err_sticky", bus.meta_err, 1'b1);

    // Asynchronous reset while a redirect is parked in HOLD
    mispredict_to_hold("rst_hold_entry");
    idle();
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    m_ctrl = 0;
    m_mis  = 0;
    m_btb  = 0;
    chk1("midrst_redirect_valid", bus.redirect_valid, 1'b0);
    chk32("midrst_redirect_pc", bus.redirect_pc, RST_PC);
    chk1("midrst_meta_err", bus.meta_err, 1'b0);
    chk1("midrst_upd_branch", bus.upd_branch, 1'b0);
    chk_cnt("midrst");
    @(negedge clk);
    rst = 1'b0;
    step();
    idle();
    bus.redirect_ready = 1'b0;
    #1;
    chk1("post_rst_run", bus.redirect_valid, 1'b0);
    step();

    chk32("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
